// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with two prioritised
// write ports, optional hardwired-zero register 0, optional write-to-read
// bypass and a per-register busy scoreboard with an occupancy counter.
module regfile_mp #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [DW-1:0] rd1,
  output logic [DW-1:0] rd2,
  output logic          rd1_busy,
  output logic          rd2_busy,
  input  logic          we0,
  input  logic [AW-1:0] wa0,
  input  logic [DW-1:0] wd0,
  input  logic          we1,
  input  logic [AW-1:0] wa1,
  input  logic [DW-1:0] wd1,
  input  logic          claim,
  input  logic [AW-1:0] claim_addr,
  output logic          claim_ok,
  output logic [AW:0]   busy_count
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0]    mem_r [DEPTH];
  logic [DEPTH-1:0] busy_r;
  logic [AW:0]      count_r;

  logic             w0_eff_s;
  logic             w1_eff_s;
  logic             claim_set_s;
  logic             inc_s;
  logic             dec0_s;
  logic             dec1_s;
  logic [DEPTH-1:0] clr_mask_s;
  logic [DEPTH-1:0] set_mask_s;
  logic [DEPTH-1:0] busy_nxt_s;
  logic [AW:0]      count_nxt_s;

  // True when address a is the hardwired-zero register.
  function automatic logic is_zero(input logic [AW-1:0] a);
    return (ZERO_REG != 1'b0) && (a == {AW{1'b0}});
  endfunction

  // Read mux: zero register, then port 1 bypass, then port 0 bypass, then storage.
  function automatic logic [DW-1:0] read_data(
    input logic [AW-1:0] ra,
    input logic [DW-1:0] stored,
    input logic          w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
    input logic          w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0
  );
    logic [DW-1:0] r;
    if (is_zero(ra)) begin
      r = {DW{1'b0}};
    end else if ((BYPASS != 1'b0) && w1 && (a1 == ra)) begin
      r = d1;
    end else if ((BYPASS != 1'b0) && w0 && (a0 == ra)) begin
      r = d0;
    end else begin
      r = stored;
    end
    return r;
  endfunction

  // Busy as seen by issue logic: a same-cycle write (with bypass) hides it.
  function automatic logic eff_busy(
    input logic          ra,
    input logic [AW-1:0] a,
    input logic          w1, input logic [AW-1:0] a1,
    input logic          w0, input logic [AW-1:0] a0
  );
    logic b;
    if (is_zero(a)) begin
      b = 1'b0;
    end else if ((BYPASS != 1'b0) && ((w1 && (a1 == a)) || (w0 && (a0 == a)))) begin
      b = 1'b0;
    end else begin
      b = ra;
    end
    return b;
  endfunction

  // Read ports, busy flags and claim acceptance; everything forced low during reset.
  always_comb begin
    rd1      = {DW{1'b0}};
    rd2      = {DW{1'b0}};
    rd1_busy = 1'b0;
    rd2_busy = 1'b0;
    claim_ok = 1'b0;
    if (!rst) begin
      rd1      = read_data(ra1, mem_r[ra1], we1, wa1, wd1, we0, wa0, wd0);
      rd2      = read_data(ra2, mem_r[ra2], we1, wa1, wd1, we0, wa0, wd0);
      rd1_busy = eff_busy(busy_r[ra1], ra1, we1, wa1, we0, wa0);
      rd2_busy = eff_busy(busy_r[ra2], ra2, we1, wa1, we0, wa0);
      claim_ok = claim & ~eff_busy(busy_r[claim_addr], claim_addr, we1, wa1, we0, wa0);
    end else begin
      claim_ok = 1'b0;
    end
  end

  // Scoreboard next state: writes clear, an accepted claim sets and wins.
  always_comb begin
    w0_eff_s    = we0 & ~is_zero(wa0);
    w1_eff_s    = we1 & ~is_zero(wa1);
    claim_set_s = claim_ok & ~is_zero(claim_addr);
    clr_mask_s  = (w0_eff_s ? ({{(DEPTH-1){1'b0}}, 1'b1} << wa0) : {DEPTH{1'b0}})
                | (w1_eff_s ? ({{(DEPTH-1){1'b0}}, 1'b1} << wa1) : {DEPTH{1'b0}});
    set_mask_s  = claim_set_s ? ({{(DEPTH-1){1'b0}}, 1'b1} << claim_addr) : {DEPTH{1'b0}};
    busy_nxt_s  = (busy_r & ~clr_mask_s) | set_mask_s;
    // Incremental occupancy: only bits that actually change contribute.
    inc_s  = claim_set_s & ~busy_r[claim_addr];
    dec1_s = w1_eff_s & busy_r[wa1] & ~(claim_set_s && (claim_addr == wa1));
    dec0_s = w0_eff_s & busy_r[wa0] & ~(claim_set_s && (claim_addr == wa0))
           & ~(w1_eff_s && (wa1 == wa0));
    count_nxt_s = count_r + {{AW{1'b0}}, inc_s} - {{AW{1'b0}}, dec1_s} - {{AW{1'b0}}, dec0_s};
  end

  // Storage: port 0 first so a colliding port 1 write overrides it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DW{1'b0}};
      end
    end else begin
      if (w0_eff_s) begin
        mem_r[wa0] <= wd0;
      end
      if (w1_eff_s) begin
        mem_r[wa1] <= wd1;
      end
    end
  end

  // Busy bits and occupancy counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r  <= {DEPTH{1'b0}};
      count_r <= {(AW+1){1'b0}};
    end else begin
      busy_r  <= busy_nxt_s;
      count_r <= count_nxt_s;
    end
  end

  assign busy_count = count_r;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (default parameters).
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk;
  logic          rst;
  logic [AW-1:0] ra1, ra2, wa0, wa1, claim_addr;
  logic [DW-1:0] rd1, rd2, wd0, wd1;
  logic          rd1_busy, rd2_busy, we0, we1, claim, claim_ok;
  logic [AW:0]   busy_count;

  int n_vec = 0;
  int n_err = 0;

  regfile_mp #(.DW(DW), .AW(AW), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .rd1_busy(rd1_busy), .rd2_busy(rd2_busy),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .claim(claim), .claim_addr(claim_addr), .claim_ok(claim_ok),
    .busy_count(busy_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0; claim = 1'b0;
  endtask

  task automatic test_reset();
    claim = 1'b1; claim_addr = 5'd5; ra1 = 5'd5; ra2 = 5'd9;
    #3;
    n_vec++; if (claim_ok !== 1'b0) begin n_err++; $display("FAIL reset_claim_ok got %0b exp 0", claim_ok); end
    n_vec++; if (busy_count !== 6'd0) begin n_err++; $display("FAIL reset_count got %0d exp 0", busy_count); end
    n_vec++; if (rd1 !== 32'd0 || rd2 !== 32'd0) begin n_err++; $display("FAIL reset_rd got %h %h exp 0", rd1, rd2); end
    @(negedge clk);
    rst = 1'b0;
    idle();
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(31 - i);
      #1;
      n_vec++;
      if (rd1 !== 32'd0 || rd2 !== 32'd0 || rd1_busy !== 1'b0 || rd2_busy !== 1'b0) begin
        n_err++; $display("FAIL reset_read a=%0d got %h %h %0b %0b exp 0", i, rd1, rd2, rd1_busy, rd2_busy);
      end
    end
  endtask

  task automatic test_bypass();
    tick();
    we1 = 1'b1; wa1 = 5'd5; wd1 = 32'hDEADBEEF; ra1 = 5'd5; ra2 = 5'd6;
    #1;
    n_vec++; if (rd1 !== 32'hDEADBEEF) begin n_err++; $display("FAIL bypass_w1 got %h exp deadbeef", rd1); end
    n_vec++; if (rd2 !== 32'd0) begin n_err++; $display("FAIL bypass_other got %h exp 0", rd2); end
    tick();
    we1 = 1'b0;
    #1;
    n_vec++; if (rd1 !== 32'hDEADBEEF) begin n_err++; $display("FAIL stored_w1 got %h exp deadbeef", rd1); end
    we0 = 1'b1; wa0 = 5'd8; wd0 = 32'd33; ra2 = 5'd8;
    #1;
    n_vec++; if (rd2 !== 32'd33) begin n_err++; $display("FAIL bypass_w0 got %h exp 21", rd2); end
    tick();
    we0 = 1'b0;
  endtask

  task automatic test_collision();
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'd1;
    we1 = 1'b1; wa1 = 5'd7; wd1 = 32'd2; ra2 = 5'd7;
    #1;
    n_vec++; if (rd2 !== 32'd2) begin n_err++; $display("FAIL collide_bypass got %h exp 2", rd2); end
    tick();
    idle(); ra1 = 5'd7;
    #1;
    n_vec++; if (rd1 !== 32'd2) begin n_err++; $display("FAIL collide_stored got %h exp 2", rd1); end
    we0 = 1'b1; wa0 = 5'd0; wd0 = 32'd9; ra1 = 5'd0;
    #1;
    n_vec++; if (rd1 !== 32'd0) begin n_err++; $display("FAIL zero_bypass got %h exp 0", rd1); end
    tick();
    idle();
    #1;
    n_vec++; if (rd1 !== 32'd0) begin n_err++; $display("FAIL zero_stored got %h exp 0", rd1); end
  endtask

  task automatic test_scoreboard();
    claim = 1'b1; claim_addr = 5'd3;
    #1;
    n_vec++; if (claim_ok !== 1'b1) begin n_err++; $display("FAIL claim3 got %0b exp 1", claim_ok); end
    tick();
    claim = 1'b0; ra1 = 5'd3;
    #1;
    n_vec++; if (busy_count !== 6'd1 || rd1_busy !== 1'b1) begin n_err++; $display("FAIL claim3_state got cnt %0d busy %0b exp 1 1", busy_count, rd1_busy); end
    claim = 1'b1; claim_addr = 5'd3;
    #1;
    n_vec++; if (claim_ok !== 1'b0) begin n_err++; $display("FAIL reclaim3 got %0b exp 0", claim_ok); end
    tick();
    claim = 1'b0;
    #1;
    n_vec++; if (busy_count !== 6'd1) begin n_err++; $display("FAIL reclaim3_cnt got %0d exp 1", busy_count); end
    claim = 1'b1; claim_addr = 5'd4; we1 = 1'b1; wa1 = 5'd3; wd1 = 32'h33;
    #1;
    n_vec++; if (claim_ok !== 1'b1 || rd1_busy !== 1'b0) begin n_err++; $display("FAIL claim4_w3 got ok %0b busy %0b exp 1 0", claim_ok, rd1_busy); end
    tick();
    idle(); ra1 = 5'd3; ra2 = 5'd4;
    #1;
    n_vec++; if (busy_count !== 6'd1) begin n_err++; $display("FAIL claim4_w3_cnt got %0d exp 1", busy_count); end
    n_vec++; if (rd1_busy !== 1'b0 || rd2_busy !== 1'b1) begin n_err++; $display("FAIL claim4_w3_busy got %0b %0b exp 0 1", rd1_busy, rd2_busy); end
    n_vec++; if (rd1 !== 32'h33) begin n_err++; $display("FAIL claim4_w3_data got %h exp 33", rd1); end
    claim = 1'b1; claim_addr = 5'd0;
    #1;
    n_vec++; if (claim_ok !== 1'b1) begin n_err++; $display("FAIL claim0 got %0b exp 1", claim_ok); end
    tick();
    claim = 1'b0;
    #1;
    n_vec++; if (busy_count !== 6'd1) begin n_err++; $display("FAIL claim0_cnt got %0d exp 1", busy_count); end
  endtask

  task automatic test_claim_write_same();
    claim = 1'b1; claim_addr = 5'd10; we0 = 1'b1; wa0 = 5'd10; wd0 = 32'hA5A5; ra1 = 5'd10;
    #1;
    n_vec++; if (claim_ok !== 1'b1) begin n_err++; $display("FAIL claim10_ok got %0b exp 1", claim_ok); end
    tick();
    idle();
    #1;
    n_vec++; if (busy_count !== 6'd2 || rd1_busy !== 1'b1 || rd1 !== 32'hA5A5) begin
      n_err++; $display("FAIL claim10_state got cnt %0d busy %0b d %h exp 2 1 a5a5", busy_count, rd1_busy, rd1);
    end
    we1 = 1'b1; wa1 = 5'd10; wd1 = 32'h11; we0 = 1'b1; wa0 = 5'd10; wd0 = 32'h22;
    tick();
    idle();
    #1;
    n_vec++; if (busy_count !== 6'd1 || rd1_busy !== 1'b0 || rd1 !== 32'h11) begin
      n_err++; $display("FAIL dual_clear got cnt %0d busy %0b d %h exp 1 0 11", busy_count, rd1_busy, rd1);
    end
  endtask

  task automatic test_async_reset();
    claim = 1'b1; claim_addr = 5'd2; tick();
    claim_addr = 5'd6; tick();
    claim_addr = 5'd9; tick();
    claim = 1'b0; we0 = 1'b1; wa0 = 5'd12; wd0 = 32'h1234; tick();
    idle(); ra1 = 5'd12; ra2 = 5'd2;
    #1;
    n_vec++; if (busy_count !== 6'd4 || rd1 !== 32'h1234 || rd2_busy !== 1'b1) begin
      n_err++; $display("FAIL pre_reset got cnt %0d d %h busy %0b exp 4 1234 1", busy_count, rd1, rd2_busy);
    end
    we1 = 1'b1; wa1 = 5'd13; wd1 = 32'h77; claim = 1'b1; claim_addr = 5'd20;
    #1;
    rst = 1'b1;
    #1;
    n_vec++; if (rd1 !== 32'd0 || rd2_busy !== 1'b0 || busy_count !== 6'd0 || claim_ok !== 1'b0) begin
      n_err++; $display("FAIL async_reset got d %h busy %0b cnt %0d ok %0b exp 0 0 0 0", rd1, rd2_busy, busy_count, claim_ok);
    end
    tick();
    idle();
    #1;
    rst = 1'b0; ra2 = 5'd13;
    #1;
    n_vec++; if (rd1 !== 32'd0 || rd2 !== 32'd0 || busy_count !== 6'd0) begin
      n_err++; $display("FAIL post_reset got %h %h cnt %0d exp 0 0 0", rd1, rd2, busy_count);
    end
    claim = 1'b1; claim_addr = 5'd2;
    #1;
    n_vec++; if (claim_ok !== 1'b1) begin n_err++; $display("FAIL post_reset_claim got %0b exp 1", claim_ok); end
    tick();
    idle();
    #1;
    n_vec++; if (busy_count !== 6'd1) begin n_err++; $display("FAIL post_reset_cnt got %0d exp 1", busy_count); end
  endtask

  initial begin
    rst = 1'b1;
    ra1 = '0; ra2 = '0; wa0 = '0; wa1 = '0; claim_addr = '0;
    wd0 = '0; wd1 = '0;
    idle();
    test_reset();
    test_bypass();
    test_collision();
    test_scoreboard();
    test_claim_write_same();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
